ddr_tile_fetcher: RTL and testbench

Read-side sequencer that walks a 2-D tile of words in DDR and streams them out for the ternary matmul datapath. It drives one requester port of the DDR arbiter: one read at a time, address held stable, r_en held until r_valid. Returned words go into a local FIFO drained by a valid/ready stream. A read is issued only when the FIFO has a free slot, so no returned word is ever dropped.

---
 rtl/ddr_tile_fetcher.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ddr_tile_fetcher.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_tile_fetcher.sv
// ddr_tile_fetcher: walks a 2-D tile of DDR words row-major (column fastest),
// issuing one arbiter read at a time, and streams the returned words out
// through a small FIFO drained by a valid/ready interface.
// A read is only launched when the FIFO can take its word, so nothing returned
// by the arbiter is ever dropped.
// ADDR_W / DATA_W are the widths of ddr_address_t / ddr_data_t.
// Optional feature macro: DDR_FETCH_TIMEOUT_EN (read timeout + sticky err_o).
module ddr_tile_fetcher #(
  parameter int FIFO_DEPTH     = 4,
  parameter int DIM_W          = 16,
  parameter int STRIDE_W       = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [STRIDE_W-1:0] stride_i,
  input  logic [DIM_W-1:0]    rows_i,
  input  logic [DIM_W-1:0]    cols_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [ADDR_W-1:0]   req_address_o,
  output logic                req_r_en_o,
  input  logic [DATA_W-1:0]   req_r_data_i,
  input  logic                req_r_valid_i,
  output logic                req_w_en_o,
  output logic [DATA_W-1:0]   m_data_o,
  output logic                m_valid_o,
  input  logic                m_ready_i
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  // Reject configurations the FIFO pointer wrap cannot handle.
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("ddr_tile_fetcher: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_READ  = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;

  logic [STRIDE_W-1:0] stride_r;
  logic [DIM_W-1:0]    rows_r;
  logic [DIM_W-1:0]    cols_r;
  logic [DIM_W-1:0]    col_r;
  logic [DIM_W-1:0]    row_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W-1:0]   row_base_r;
  logic [ADDR_W-1:0]   stride_ext_s;

  logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [PTR_W:0]      count_r;

  logic                start_acc_s;
  logic                zero_dim_s;
  logic                push_s;
  logic                pop_s;
  logic                slot_free_s;
  logic                last_col_s;
  logic                last_elem_s;
  logic                timeout_s;

  assign start_acc_s  = start_i && (state_r == ST_IDLE);
  assign zero_dim_s   = (rows_i == {DIM_W{1'b0}}) || (cols_i == {DIM_W{1'b0}});
  // Stride is zero-extended (or truncated) to the address width; sums wrap.
  assign stride_ext_s = ADDR_W'(stride_r);
  assign push_s       = (state_r == ST_READ) && req_r_valid_i;
  assign pop_s        = (count_r != {(PTR_W+1){1'b0}}) && m_ready_i;
  // A pop in the same cycle frees a slot before the next read can return.
  assign slot_free_s  = (count_r < FULL_CNT) || pop_s;
  assign last_col_s   = (col_r == (cols_r - DIM_W'(1)));
  assign last_elem_s  = last_col_s && (row_r == (rows_r - DIM_W'(1)));

`ifdef DDR_FETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             err_r;

  assign timeout_s = (state_r == ST_READ) && !req_r_valid_i &&
                     (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

  // Cycles spent waiting in READ; held at zero outside READ so each entry starts fresh.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else if (state_r != ST_READ) begin
      tmo_cnt_r <= {TMO_W{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end
  end

  // Sticky timeout flag, cleared only by the next accepted command.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else if (start_acc_s) begin
      err_r <= 1'b0;
    end else if (timeout_s) begin
      err_r <= 1'b1;
    end
  end

  assign err_o = err_r;
`else
  assign timeout_s = 1'b0;
  assign err_o     = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_s = zero_dim_s ? ST_FIN : ST_CHECK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (slot_free_s) begin
          state_s = ST_READ;
        end else begin
          state_s = ST_CHECK;
        end
      end
      ST_READ: begin
        if (push_s) begin
          state_s = last_elem_s ? ST_FIN : ST_CHECK;
        end else if (timeout_s) begin
          state_s = ST_FIN;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_FIN: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs, decoded from the state register only.
  always_comb begin
    req_r_en_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_o = 1'b0;
      end
      ST_CHECK: begin
        busy_o = 1'b1;
      end
      ST_READ: begin
        busy_o     = 1'b1;
        req_r_en_o = 1'b1;
      end
      ST_FIN: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // Command capture and incremental (row, column, address) walk.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stride_r   <= {STRIDE_W{1'b0}};
      rows_r     <= {DIM_W{1'b0}};
      cols_r     <= {DIM_W{1'b0}};
      col_r      <= {DIM_W{1'b0}};
      row_r      <= {DIM_W{1'b0}};
      addr_r     <= {ADDR_W{1'b0}};
      row_base_r <= {ADDR_W{1'b0}};
    end else if (start_acc_s) begin
      stride_r   <= stride_i;
      rows_r     <= rows_i;
      cols_r     <= cols_i;
      col_r      <= {DIM_W{1'b0}};
      row_r      <= {DIM_W{1'b0}};
      addr_r     <= base_addr_i;
      row_base_r <= base_addr_i;
    end else if (push_s) begin
      if (last_col_s) begin
        col_r      <= {DIM_W{1'b0}};
        row_r      <= row_r + DIM_W'(1);
        row_base_r <= row_base_r + stride_ext_s;
        addr_r     <= row_base_r + stride_ext_s;
      end else begin
        col_r      <= col_r + DIM_W'(1);
        addr_r     <= addr_r + ADDR_W'(1);
      end
    end
  end

  // FIFO storage; cleared on reset so stale words never reappear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= req_r_data_i;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign req_address_o = addr_r;
  assign req_w_en_o    = 1'b0;
  assign m_valid_o     = (count_r != {(PTR_W+1){1'b0}});
  assign m_data_o      = mem_r[rd_ptr_r];

endmodule

// File: tb/tb_ddr_tile_fetcher.sv
// Self-checking bench for ddr_tile_fetcher: a randomised arbiter and stream
// sink drive the block while a queue-based reference model predicts the read
// address sequence, stream contents, done/busy/err timing and FIFO occupancy.
module tb_ddr_tile_fetcher;

  localparam int DEPTH  = 4;
  localparam int DIM_W  = 16;
  localparam int STR_W  = 32;
  localparam int TMO    = 16;
  localparam int AW     = 32;
  localparam int DW     = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [STR_W-1:0] stride = '0;
  logic [DIM_W-1:0] rows = '0;
  logic [DIM_W-1:0] cols = '0;
  logic             busy_o, done_o, err_o, r_en, w_en, m_valid;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    r_data = '0;
  logic             r_valid = 1'b0;
  logic [DW-1:0]    m_data;
  logic             m_ready = 1'b1;

  ddr_tile_fetcher #(
    .FIFO_DEPTH(DEPTH), .DIM_W(DIM_W), .STRIDE_W(STR_W),
    .TIMEOUT_CYCLES(TMO), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr),
    .stride_i(stride), .rows_i(rows), .cols_i(cols), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .req_address_o(addr), .req_r_en_o(r_en),
    .req_r_data_i(r_data), .req_r_valid_i(r_valid), .req_w_en_o(w_en),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus knobs (written by the main process only)
  int fixed_lat  = 3;   // -1 selects a random latency per read
  bit mute       = 1'b0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
  int stray_req  = 0;

  // ---------------- arbiter model
  initial begin : arbiter
    int lat_cnt;
    int cur_lat;
    int stray_done;
    lat_cnt = 0; cur_lat = 3; stray_done = 0;
    forever begin
      @(posedge clk); #1;
      r_valid = 1'b0;
      if (rst) begin
        lat_cnt = 0;
      end else if (r_en && !mute) begin
        if (lat_cnt == 0) cur_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
        if (lat_cnt >= cur_lat) begin
          r_valid = 1'b1;
          r_data  = $urandom;
          lat_cnt = 0;
        end else begin
          lat_cnt++;
        end
      end else if (!r_en) begin
        lat_cnt = 0;
        if (stray_done < stray_req) begin
          r_valid = 1'b1;
          r_data  = $urandom;
          stray_done++;
        end
      end
    end
  end

  // ---------------- stream sink
  initial begin : sink
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // ---------------- reference model and per-cycle compare
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] data_q[$];
  logic [AW-1:0] seen_addr[$];
  bit            m_busy = 0, exp_done = 0, m_err = 0;
  int            wait_cnt = 0;
  int            done_seen = 0, reads_seen = 0, beats_seen = 0;
  bit            prev_r_en = 0, prev_push = 0, prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;
  logic [AW-1:0] a;

  always @(negedge clk) begin : compare
    bit nb, nd, ne;
    if (rst) begin
      check_eq("reset_r_en", r_en, 0);
      check_eq("reset_m_valid", m_valid, 0);
      check_eq("reset_busy", busy_o, 0);
      check_eq("reset_done", done_o, 0);
      check_eq("reset_err", err_o, 0);
      addr_q.delete(); data_q.delete();
      m_busy = 0; exp_done = 0; m_err = 0; wait_cnt = 0;
      prev_r_en = 0; prev_push = 0; prev_stall = 0;
    end else begin
      check_eq("busy", busy_o, m_busy);
      check_eq("done", done_o, exp_done);
      check_eq("err", err_o, m_err);
      check_eq("m_valid", m_valid, data_q.size() != 0);
      check_eq("w_en", w_en, 0);
      if (prev_stall) check_eq("head_stable", m_data, prev_data);
      if (r_en) begin
        if (addr_q.size() == 0) check_eq("spurious_read", r_en, 0);
        else check_eq("read_addr", addr, addr_q[0]);
        if (prev_r_en) check_eq("addr_stable", addr, prev_addr);
        if (prev_push) check_eq("read_gap", prev_push, 0);
      end
      nb = m_busy; nd = 0; ne = m_err;
      if (done_o) begin nb = 0; done_seen++; end
      if (m_valid && m_ready) begin
        beats_seen++;
        if (data_q.size() == 0) check_eq("unexpected_beat", m_valid, 0);
        else check_eq("stream_data", m_data, data_q.pop_front());
      end
      if (r_en && r_valid) begin
        data_q.push_back(r_data);
        seen_addr.push_back(addr);
        reads_seen++;
        if (addr_q.size() != 0) void'(addr_q.pop_front());
        if (addr_q.size() == 0) nd = 1;
        wait_cnt = 0;
      end else if (r_en) begin
        wait_cnt++;
`ifdef DDR_FETCH_TIMEOUT_EN
        if (wait_cnt == TMO) begin
          addr_q.delete(); nd = 1; ne = 1; wait_cnt = 0;
        end
`endif
      end else begin
        wait_cnt = 0;
      end
      check_eq("fifo_bound", data_q.size() <= DEPTH, 1);
      if (start && !m_busy) begin
        nb = 1; ne = 0;
        for (int r = 0; r < int'(rows); r++)
          for (int c = 0; c < int'(cols); c++) begin
            a = AW'(64'(base_addr) + 64'(r) * 64'(stride) + 64'(c));
            addr_q.push_back(a);
          end
        if (addr_q.size() == 0) nd = 1;
      end
      m_busy = nb; exp_done = nd; m_err = ne;
      prev_r_en = r_en; prev_addr = addr; prev_push = r_en && r_valid;
      prev_stall = m_valid && !m_ready; prev_data = m_data;
    end
  end

  // ---------------- driver helpers (all at posedge + 1)
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [AW-1:0] b, input logic [STR_W-1:0] s,
                      input logic [DIM_W-1:0] r, input logic [DIM_W-1:0] c);
    start = 1'b1; base_addr = b; stride = s; rows = r; cols = c;
    step();
    start = 1'b0; base_addr = $urandom; stride = $urandom; rows = $urandom; cols = $urandom;
  endtask

  task automatic wait_done(input int d0, input int bound, input string name);
    int i;
    for (i = 0; i < bound; i++) begin
      if (done_seen > d0) break;
      step();
    end
    if (done_seen <= d0) check_eq({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_drain(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      if (data_q.size() == 0 && !m_valid) break;
      step();
    end
    check_eq("drain", data_q.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic [AW-1:0] exp_basic [6];
  initial begin : main
    int d0, r0, b0, cnt;
    exp_basic[0] = 32'h100; exp_basic[1] = 32'h101; exp_basic[2] = 32'h102;
    exp_basic[3] = 32'h108; exp_basic[4] = 32'h109; exp_basic[5] = 32'h10A;

    repeat (3) step();
    check_eq("rst_state_busy", busy_o, 0);
    check_eq("rst_state_m_valid", m_valid, 0);
    rst = 1'b0;
    step();

    // Basic tile
    fixed_lat = 3; ready_mode = 0; seen_addr.delete();
    d0 = done_seen; b0 = beats_seen;
    send(32'h100, 32'd8, 16'd2, 16'd3);
    check_eq("ren_lat_cycle1", r_en, 0);
    step();
    check_eq("ren_lat_cycle2", r_en, 1);
    wait_done(d0, 200, "basic");
    check_eq("busy_after_done", busy_o, 0);
    wait_drain(50);
    check_eq("basic_reads", seen_addr.size(), 6);
    for (int i = 0; i < 6 && i < seen_addr.size(); i++) check_eq("basic_addr", seen_addr[i], exp_basic[i]);
    check_eq("basic_beats", beats_seen - b0, 6);
    check_eq("basic_done_count", done_seen - d0, 1);

    // Backpressure
    fixed_lat = 1; ready_mode = 2; r0 = reads_seen; b0 = beats_seen; d0 = done_seen;
    send(32'h4000, 32'd3, 16'd1, 16'd8);
    repeat (40) step();
    check_eq("bp_reads_blocked", reads_seen - r0, 4);
    check_eq("bp_ren_low", r_en, 0);
    ready_mode = 0;
    wait_done(d0, 200, "bp");
    wait_drain(50);
    check_eq("bp_reads_total", reads_seen - r0, 8);
    check_eq("bp_beats_total", beats_seen - b0, 8);

    // Zero dimensions
    r0 = reads_seen;
    send(32'h0, 32'd1, 16'd0, 16'd5);
    check_eq("zero_rows_done", done_o, 1);
    step();
    check_eq("zero_rows_idle", busy_o, 0);
    send(32'h0, 32'd1, 16'd3, 16'd0);
    check_eq("zero_cols_done", done_o, 1);
    step();
    check_eq("zero_cols_idle", busy_o, 0);
    check_eq("zero_no_reads", reads_seen - r0, 0);

    // Address wrap
    seen_addr.delete(); d0 = done_seen;
    send(32'hFFFF_FFFE, 32'd0, 16'd1, 16'd3);
    wait_done(d0, 100, "wrap");
    wait_drain(50);
    check_eq("wrap_reads", seen_addr.size(), 3);
    if (seen_addr.size() == 3) begin
      check_eq("wrap_addr0", seen_addr[0], 32'hFFFF_FFFE);
      check_eq("wrap_addr1", seen_addr[1], 32'hFFFF_FFFF);
      check_eq("wrap_addr2", seen_addr[2], 32'h0000_0000);
    end

    // Start while busy, then asynchronous reset mid-READ
    fixed_lat = 4; seen_addr.delete(); r0 = reads_seen;
    send(32'h2000, 32'd16, 16'd2, 16'd4);
    step();
    start = 1'b1; base_addr = 32'h9999_0000; rows = 16'd1; cols = 16'd1;
    step();
    start = 1'b0;
    for (int i = 0; i < 60 && reads_seen - r0 < 2; i++) step();
    cnt = 0;
    while (!r_en && cnt < 20) begin step(); cnt++; end
    check_eq("busy_start_ignored_a0", seen_addr.size() > 0 ? seen_addr[0] : 32'h0, 32'h2000);
    check_eq("busy_start_ignored_a1", seen_addr.size() > 1 ? seen_addr[1] : 32'h0, 32'h2001);
    check_eq("pre_reset_in_read", r_en, 1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_ren", r_en, 0);
    check_eq("async_rst_m_valid", m_valid, 0);
    check_eq("async_rst_busy", busy_o, 0);
    step(); step();
    rst = 1'b0;
    step();
    fixed_lat = 0; d0 = done_seen; seen_addr.delete();
    send(32'h500, 32'd2, 16'd2, 16'd1);
    wait_done(d0, 100, "post_reset");
    wait_drain(50);
    check_eq("post_reset_reads", seen_addr.size(), 2);
    check_eq("post_reset_addr1", seen_addr.size() > 1 ? seen_addr[1] : 32'h0, 32'h502);

    // Randomised commands, random latency/ready, stray valids, back-to-back queuing
    fixed_lat = -1; ready_mode = 1;
    for (int it = 0; it < 12; it++) begin
      if (it % 3 == 0) begin stray_req++; step(); step(); end
      d0 = done_seen;
      send($urandom, 32'($urandom_range(0, 40)), 16'($urandom_range(0, 3)), 16'($urandom_range(0, 4)));
      wait_done(d0, 800, "rand");
      step();
      if (it % 2 == 1) wait_drain(200);
    end
    wait_drain(200);

`ifdef DDR_FETCH_TIMEOUT_EN
    // Timeout: arbiter never answers
    ready_mode = 0; mute = 1'b1; d0 = done_seen;
    send(32'h7000, 32'd4, 16'd1, 16'd2);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (r_en) cnt++;
      step();
    end
    check_eq("tmo_ren_cycles", cnt, TMO);
    check_eq("tmo_err_set", err_o, 1);
    check_eq("tmo_done_count", done_seen - d0, 1);
    mute = 1'b0; fixed_lat = 1; d0 = done_seen;
    send(32'h7100, 32'd1, 16'd1, 16'd1);
    check_eq("tmo_err_cleared", err_o, 0);
    wait_done(d0, 100, "tmo_next");
    wait_drain(50);
`endif

    repeat (5) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
